// File: rtl/fir_coef_loader_if.sv
// Byte-stream input and filter-bank coefficient port of the FIR coefficient loader.
interface fir_coef_loader_if;
    logic       frame_start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic [5:0] coef_select;
    logic       coefs_per_tap_msb;
    logic [7:0] coefs_per_tap_lsb;
    logic       coef_addr_rst;
    logic [7:0] coef_wr_msb_data;
    logic [7:0] coef_wr_lsb_data;
    logic       coefficient_wr_en;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        input  frame_start, byte_valid, byte_data,
        output byte_ready, coef_select, coefs_per_tap_msb, coefs_per_tap_lsb,
               coef_addr_rst, coef_wr_msb_data, coef_wr_lsb_data,
               coefficient_wr_en, busy, done, error
    );

    modport slave (
        output frame_start, byte_valid, byte_data,
        input  byte_ready, coef_select, coefs_per_tap_msb, coefs_per_tap_lsb,
               coef_addr_rst, coef_wr_msb_data, coef_wr_lsb_data,
               coefficient_wr_en, busy, done, error
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Parses a byte-framed coefficient upload and writes it into the FIR bank,
// spacing write strobes so the bank's delayed address increment completes.
module fir_coef_loader #(
    parameter int unsigned NUM_FILTERS = 4,
    parameter int unsigned WR_GAP      = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    fir_coef_loader_if.master bus
);
    localparam int unsigned GAP_W = $clog2(WR_GAP) + 1;
    localparam int unsigned TAP_W = 9;

    typedef enum logic [3:0] {
        IDLE, SEL, CPT_H, CPT_L, ARST, C_MSB, C_LSB, WRITE, GAP, FIN
    } state_t;

    state_t             state, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [5:0]         sel_q, sel_d;
    logic               cpt_msb_q, cpt_msb_d;
    logic [7:0]         cpt_lsb_q, cpt_lsb_d;
    logic [7:0]         msb_q, msb_d, lsb_q, lsb_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic               arst_q, arst_d, wr_q, wr_d;
    logic               accept;

    // frame_start takes priority over a byte offered in the same cycle
    assign bus.byte_ready = ready_q & ~bus.frame_start;
    assign accept         = bus.byte_valid & bus.byte_ready;

    always_comb begin
        state_d   = state;
        tap_d     = tap_q;
        gap_d     = gap_q;
        sel_d     = sel_q;
        cpt_msb_d = cpt_msb_q;
        cpt_lsb_d = cpt_lsb_q;
        msb_d     = msb_q;
        lsb_d     = lsb_q;
        err_d     = err_q;

        if (bus.frame_start) begin
            state_d = SEL;
            err_d   = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                SEL: if (accept) begin
                    if (32'(bus.byte_data[5:0]) >= NUM_FILTERS) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sel_d   = bus.byte_data[5:0];
                        state_d = CPT_H;
                    end
                end
                CPT_H: if (accept) begin
                    cpt_msb_d = bus.byte_data[0];
                    state_d   = CPT_L;
                end
                CPT_L: if (accept) begin
                    cpt_lsb_d = bus.byte_data;
                    if ({cpt_msb_q, bus.byte_data} == 9'd0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ARST;
                    end
                end
                ARST: begin
                    tap_d   = '0;
                    state_d = C_MSB;
                end
                C_MSB: if (accept) begin
                    msb_d   = bus.byte_data;
                    state_d = C_LSB;
                end
                C_LSB: if (accept) begin
                    lsb_d   = bus.byte_data;
                    state_d = WRITE;
                end
                WRITE: begin
                    tap_d   = tap_q + 9'd1;
                    gap_d   = GAP_W'(WR_GAP - 2);
                    state_d = GAP;
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_d = (tap_q == {cpt_msb_q, cpt_lsb_q}) ? FIN : C_MSB;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Registered outputs are decoded from the state being entered
        ready_d = (state_d == SEL) || (state_d == CPT_H) || (state_d == CPT_L) ||
                  (state_d == C_MSB) || (state_d == C_LSB);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        arst_d  = (state_d == ARST);
        wr_d    = (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            tap_q     <= '0;
            gap_q     <= '0;
            sel_q     <= '0;
            cpt_msb_q <= 1'b0;
            cpt_lsb_q <= '0;
            msb_q     <= '0;
            lsb_q     <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arst_q    <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state     <= state_d;
            tap_q     <= tap_d;
            gap_q     <= gap_d;
            sel_q     <= sel_d;
            cpt_msb_q <= cpt_msb_d;
            cpt_lsb_q <= cpt_lsb_d;
            msb_q     <= msb_d;
            lsb_q     <= lsb_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            arst_q    <= arst_d;
            wr_q      <= wr_d;
        end
    end

    assign bus.coef_select       = sel_q;
    assign bus.coefs_per_tap_msb = cpt_msb_q;
    assign bus.coefs_per_tap_lsb = cpt_lsb_q;
    assign bus.coef_addr_rst     = arst_q;
    assign bus.coef_wr_msb_data  = msb_q;
    assign bus.coef_wr_lsb_data  = lsb_q;
    assign bus.coefficient_wr_en = wr_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.error             = err_q;
endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Host-side writer for the FIR filter bank coefficient port.
- Parses a byte-framed coefficient upload from the control register/SPI byte stream.
- Drives the filter bank's coefficient interface: select, address reset, MSB/LSB data, write strobe and coefs-per-tap.
- Spaces write strobes so the bank's delayed address auto-increment completes between writes. Reports done/error per frame.

Parameters:
- NUM_FILTERS, 4: number of coefficient RAMs in the bank. Valid select range is 0..NUM_FILTERS-1.
- WR_GAP, 6: minimum number of clocks from one coefficient_wr_en pulse to the next. Must be at least 6, because the bank increments its write address 5 clocks after the strobe.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  1-clk pulse. Aborts any frame in progress and starts parsing a new one.
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  frame byte
- byte_ready  out  1  loader accepts byte_data this cycle
- coef_select  out  6  target RAM index
- coefs_per_tap_msb  out  1  bit 8 of coefs-per-tap
- coefs_per_tap_lsb  out  8  bits 7:0 of coefs-per-tap
- coef_addr_rst  out  1  1-clk pulse that resets the bank write address
- coef_wr_msb_data  out  8  coefficient bits 15:8
- coef_wr_lsb_data  out  8  coefficient bits 7:0
- coefficient_wr_en  out  1  1-clk write strobe
- busy  out  1  frame in progress
- done  out  1  1-clk pulse when a frame completes without error
- error  out  1  sticky frame error. Cleared by frame_start or reset.

Behaviour:
- Frame format, in byte order:
  - SEL: byte[5:0] = select; byte[7:6] ignored.
  - CPT_H: byte[0] = coefs_per_tap[8].
  - CPT_L: coefs_per_tap[7:0].
  - Then N = coefs_per_tap pairs, each MSB byte followed by LSB byte.
- Byte handshake: a byte is consumed only on a cycle where byte_valid and byte_ready are both high.
- byte_ready is high only in states SEL, CPT_H, CPT_L, C_MSB and C_LSB; low in all other states.
- Reset values: byte_ready=0, busy=0, done=0, error=0, coefficient_wr_en=0, coef_addr_rst=0; all data/select/cpt outputs 0; state IDLE; tap counter 0.
- FSM states: IDLE, SEL, CPT_H, CPT_L, ARST, C_MSB, C_LSB, WRITE, GAP, FIN.
  - IDLE: on frame_start go to SEL and clear error. Bytes offered in IDLE are not accepted.
  - SEL: on an accepted byte, if byte[5:0] >= NUM_FILTERS: set error, go to IDLE. Otherwise latch coef_select and go to CPT_H.
  - CPT_H: latch coefs_per_tap_msb and go to CPT_L.
  - CPT_L: latch coefs_per_tap_lsb. If the resulting 9-bit value is 0: set error, go to IDLE. Otherwise go to ARST.
  - ARST: coef_addr_rst=1 for exactly 1 clk, tap counter := 0, go to C_MSB.
  - C_MSB: latch coef_wr_msb_data, go to C_LSB.
  - C_LSB: latch coef_wr_lsb_data, go to WRITE.
  - WRITE: coefficient_wr_en=1 for exactly 1 clk, tap counter +1, gap counter := WR_GAP-2, go to GAP.
  - GAP: decrement the gap counter. At 0: if tap counter == coefs_per_tap go to FIN, else go to C_MSB.
  - FIN: done=1 for 1 clk, go to IDLE.
- Data and select are held stable from the latch cycle through the end of GAP, because the bank samples data on the strobe cycle and registers the select mux 1 clk later.
- Spacing guarantee:
  - Strobe-to-strobe distance is at least WR_GAP clocks, even with byte_valid held high continuously.
  - With continuous bytes, the strobe period is exactly WR_GAP+2 clocks (GAP plus the two byte states).
- busy is 1 in every state except IDLE.
- frame_start in any state, including mid-GAP:
  - Goes to SEL next clk; clears error; drops the current frame.
  - A strobe already issued is not retracted; the next ARST re-zeros the bank address.
- frame_start and byte_valid in the same cycle: frame_start wins and the byte is not consumed (byte_ready=0 that cycle).
- reset_n low mid-frame: all outputs return to reset values on the next edge; no strobe is issued.
- coefs_per_tap = 511 (maximum): 511 writes; the counter is 9 bits wide with no wrap.
- Outputs keep their last values after FIN and after error, until the next latch.

Test Plan:
- Basic frame:
  - Stimulus: frame_start; bytes 02,00,03, then 12,34, AB,CD, 80,01, all continuous.
  - Required: one coef_addr_rst pulse; 3 wr_en pulses carrying 0x1234, 0xABCD, 0x8001; coef_select=2; cpt outputs 0/0x03; strobes 8 clks apart; done pulse; busy cleared.
- Gap under flow control:
  - Stimulus: same frame with byte_valid toggled 1-of-3 cycles.
  - Required: strobe spacing >= 6 and each pulse's data matches its pair; byte_ready low throughout WRITE/GAP.
- Select error:
  - Stimulus: SEL byte 04 with NUM_FILTERS=4.
  - Required: error=1, no coef_addr_rst or wr_en, returns to IDLE. The next frame_start clears error.
- Zero count:
  - Stimulus: bytes 01,00,00.
  - Required: error=1, no coef_addr_rst, no writes.
- Abort mid-frame:
  - Stimulus: frame_start during GAP after 1 of 3 writes, followed by a full 1-coef frame for select 0.
  - Required: new coef_addr_rst; a single wr_en with the new data; done; no further writes from the old frame.
- Max count and reset:
  - Stimulus: cpt=0x1FF frame.
  - Required: exactly 511 strobes, then done.
  - Stimulus: repeat the frame with reset_n low after 10 writes.
  - Required: all outputs 0 on the next clk; no further strobes.
